// File: rtl/layer_2_5_pkg.sv
// Shared lane count, lane index type and accumulator width helper for the layer 2.5 result drain.
// Pure definitions: no latency, no flow control.
package layer_2_5_pkg;

    localparam int NUM_LANES = 5;

    typedef logic [2:0] lane_idx_t;

    function automatic int acc_width(input int vector_size, input int multiplier_size);
        return vector_size + multiplier_size + 1;
    endfunction

endpackage

// File: rtl/layer_2_5_quantize.sv
// Quantiser: logical right shift, then unsigned saturation to OUT_SIZE bits.
// Purely combinational (0 cycles); no flow control.
module layer_2_5_quantize #(
    parameter int ACC_WIDTH = 17,
    parameter int SHIFT     = 4,
    parameter int OUT_SIZE  = 8
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_SIZE-1:0]  q,
    output logic                 sat
);

    // When the output is at least as wide as the accumulator, nothing can saturate.
    localparam logic [ACC_WIDTH-1:0] Q_MAX = (OUT_SIZE >= ACC_WIDTH) ? {ACC_WIDTH{1'b1}}
                                           : ACC_WIDTH'((64'd1 << OUT_SIZE) - 64'd1);

    logic [ACC_WIDTH-1:0] shifted;

    assign shifted = acc >> SHIFT;
    assign sat     = (shifted > Q_MAX);
    assign q       = sat ? {OUT_SIZE{1'b1}} : OUT_SIZE'(shifted);

endmodule

// File: rtl/layer_2_5_result_drain.sv
// Captures five MAC lanes into a ping-pong bank pair and streams them out quantised, one lane per beat.
// First beat 1 cycle after capture; out_ready=0 holds the beat, and a capture with both banks full is dropped (sticky overflow).
module layer_2_5_result_drain
    import layer_2_5_pkg::*;
#(
    parameter int  VECTOR_SIZE     = 8,
    parameter int  MULTIPLIER_SIZE = 8,
    parameter int  SHIFT           = 4,
    parameter int  OUT_SIZE        = 8,
    localparam int ACC_WIDTH       = acc_width(VECTOR_SIZE, MULTIPLIER_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_valid,
    input  logic [ACC_WIDTH-1:0] acc_1,
    input  logic [ACC_WIDTH-1:0] acc_2,
    input  logic [ACC_WIDTH-1:0] acc_3,
    input  logic [ACC_WIDTH-1:0] acc_4,
    input  logic [ACC_WIDTH-1:0] acc_5,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_SIZE-1:0]  out_data,
    output logic [2:0]           out_index,
    output logic                 out_last,
    output logic                 out_sat,
    output logic                 overflow
);

    localparam lane_idx_t LAST_IDX = lane_idx_t'(NUM_LANES - 1);

    logic [ACC_WIDTH-1:0] acc_lane [NUM_LANES];
    logic [ACC_WIDTH-1:0] bank_q   [2][NUM_LANES];

    logic [1:0] bank_full_q, bank_full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    lane_idx_t  rd_idx_q, rd_idx_d;
    logic       overflow_q, overflow_d;

    logic                 beat_xfer, last_xfer, wr_avail, capture;
    logic [ACC_WIDTH-1:0] rd_acc;
    logic [OUT_SIZE-1:0]  q_data;
    logic                 q_sat;

    assign acc_lane[0] = acc_1;
    assign acc_lane[1] = acc_2;
    assign acc_lane[2] = acc_3;
    assign acc_lane[3] = acc_4;
    assign acc_lane[4] = acc_5;

    assign out_valid = bank_full_q[rd_bank_q];
    assign beat_xfer = out_valid && out_ready;
    assign last_xfer = beat_xfer && (rd_idx_q == LAST_IDX);
    // A bank emptying on this very edge may be refilled on the same edge.
    assign wr_avail  = !bank_full_q[wr_bank_q] || (last_xfer && (rd_bank_q == wr_bank_q));
    assign capture   = acc_valid && wr_avail;

    always_comb begin
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        overflow_d  = overflow_q;
        if (beat_xfer) begin
            if (last_xfer) begin
                rd_idx_d               = '0;
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + 3'd1;
            end
        end
        // Set after the release so a same-bank capture leaves the bank full.
        if (acc_valid) begin
            if (wr_avail) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                bank_q[wr_bank_q][i] <= acc_lane[i];
            end
        end
    end

    assign rd_acc = bank_q[rd_bank_q][rd_idx_q];

    layer_2_5_quantize #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_SIZE  (OUT_SIZE)
    ) u_quantize (
        .acc (rd_acc),
        .q   (q_data),
        .sat (q_sat)
    );

    // Data lanes carry no reset, so mask them while nothing is presented.
    assign out_data  = out_valid ? q_data : '0;
    assign out_sat   = out_valid && q_sat;
    assign out_index = rd_idx_q;
    assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_layer_2_5_result_drain.sv
// Directed bench for layer_2_5_result_drain: one instance with SHIFT=0, one with SHIFT=4, shared stimulus.
module tb_layer_2_5_result_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        acc_valid;
    logic        out_ready;
    logic [16:0] acc_1, acc_2, acc_3, acc_4, acc_5;

    logic       v0, l0, s0, o0;
    logic [7:0] d0;
    logic [2:0] i0;
    logic       v4, l4, s4, o4;
    logic [7:0] d4;
    logic [2:0] i4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    layer_2_5_result_drain #(.VECTOR_SIZE(8), .MULTIPLIER_SIZE(8), .SHIFT(0), .OUT_SIZE(8)) u_dut0 (
        .clk(clk), .reset(reset), .acc_valid(acc_valid),
        .acc_1(acc_1), .acc_2(acc_2), .acc_3(acc_3), .acc_4(acc_4), .acc_5(acc_5),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_index(i0),
        .out_last(l0), .out_sat(s0), .overflow(o0)
    );

    layer_2_5_result_drain #(.VECTOR_SIZE(8), .MULTIPLIER_SIZE(8), .SHIFT(4), .OUT_SIZE(8)) u_dut4 (
        .clk(clk), .reset(reset), .acc_valid(acc_valid),
        .acc_1(acc_1), .acc_2(acc_2), .acc_3(acc_3), .acc_4(acc_4), .acc_5(acc_5),
        .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_index(i4),
        .out_last(l4), .out_sat(s4), .overflow(o4)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input int a1, input int a2, input int a3, input int a4, input int a5);
        acc_1 = 17'(a1); acc_2 = 17'(a2); acc_3 = 17'(a3); acc_4 = 17'(a4); acc_5 = 17'(a5);
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({v0, d0, i0, l0, s0, o0} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b d=%0d i=%0d l=%0b s=%0b ovf=%0b want all 0", v0, d0, i0, l0, s0, o0);
        end
    endtask

    task automatic test_basic();
        logic [13:0] exp;
        out_ready = 1'b1;
        pulse(14, 14, 14, 14, 14);
        for (int k = 0; k < 5; k++) begin
            exp = {1'b1, 8'd14, 3'(k), (k == 4), 1'b0};
            checks++;
            if ({v0, d0, i0, l0, s0} !== exp) begin
                errors++;
                $display("FAIL basic_beat%0d: got v/d/i/l/s=%h want %h", k, {v0, d0, i0, l0, s0}, exp);
            end
            step();
        end
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got out_valid=%0b want 0", v0);
        end
    endtask

    task automatic test_quantize();
        logic [9:0] exp0, exp4;
        out_ready = 1'b1;
        pulse(3000, 994, 994, 994, 994);
        for (int k = 0; k < 5; k++) begin
            exp0 = {1'b1, 8'd255, 1'b1};
            exp4 = {1'b1, (k == 0) ? 8'd187 : 8'd62, 1'b0};
            checks++;
            if ({v0, d0, s0} !== exp0) begin
                errors++;
                $display("FAIL quant_shift0_beat%0d: got v/d/s=%h want %h", k, {v0, d0, s0}, exp0);
            end
            checks++;
            if ({v4, d4, s4} !== exp4) begin
                errors++;
                $display("FAIL quant_shift4_beat%0d: got v/d/s=%h want %h", k, {v4, d4, s4}, exp4);
            end
            step();
        end
    endtask

    task automatic test_stall();
        int exp_idx;
        logic [12:0] exp;
        exp_idx = 0;
        out_ready = 1'b0;
        pulse(1, 2, 3, 4, 5);
        for (int c = 0; c < 40 && exp_idx < 5; c++) begin
            out_ready = (c % 3 == 0);
            exp = {1'b1, 8'(exp_idx + 1), 3'(exp_idx), (exp_idx == 4)};
            checks++;
            if ({v0, d0, i0, l0} !== exp) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v/d/i/l=%h want %h", c, {v0, d0, i0, l0}, exp);
            end
            step();
            if (out_ready) exp_idx++;
        end
        checks++;
        if (exp_idx != 5 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: got beats=%0d out_valid=%0b want beats=5 out_valid=0", exp_idx, v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        out_ready = 1'b1;
        pulse(10, 11, 12, 13, 14);
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin
                acc_1 = 17'd20; acc_2 = 17'd21; acc_3 = 17'd22; acc_4 = 17'd23; acc_5 = 17'd24;
                acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
            exp = {1'b1, 8'((k < 5 ? 10 : 20) + k % 5), 3'(k % 5), (k % 5 == 4)};
            checks++;
            if ({v0, d0, i0, l0} !== exp) begin
                errors++;
                $display("FAIL b2b_beat%0d: got v/d/i/l=%h want %h", k, {v0, d0, i0, l0}, exp);
            end
            step();
        end
        checks++;
        if ({v0, o0} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: got out_valid=%0b overflow=%0b want 0 0", v0, o0);
        end
    endtask

    task automatic test_same_edge();
        logic [12:0] exp;
        int base;
        out_ready = 1'b0;
        pulse(100, 101, 102, 103, 104);
        pulse(110, 111, 112, 113, 114);
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 4) begin
                acc_1 = 17'd120; acc_2 = 17'd121; acc_3 = 17'd122; acc_4 = 17'd123; acc_5 = 17'd124;
                acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
            base = (k < 5) ? 100 : (k < 10) ? 110 : 120;
            exp = {1'b1, 8'(base + k % 5), 3'(k % 5), (k % 5 == 4)};
            checks++;
            if ({v0, d0, i0, l0} !== exp) begin
                errors++;
                $display("FAIL same_edge_beat%0d: got v/d/i/l=%h want %h", k, {v0, d0, i0, l0}, exp);
            end
            step();
        end
        checks++;
        if ({v0, o0} !== 2'b00) begin
            errors++;
            $display("FAIL same_edge_end: got out_valid=%0b overflow=%0b want 0 0", v0, o0);
        end
    endtask

    task automatic test_overflow();
        logic [12:0] exp;
        out_ready = 1'b0;
        pulse(31, 32, 33, 34, 35);
        pulse(41, 42, 43, 44, 45);
        checks++;
        if (o0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_two_pending: got overflow=%0b want 0", o0);
        end
        pulse(51, 52, 53, 54, 55);
        checks++;
        if (o0 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_third: got overflow=%0b want 1", o0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp = {1'b1, 8'((k < 5 ? 31 : 41) + k % 5), 3'(k % 5), (k % 5 == 4)};
            checks++;
            if ({v0, d0, i0, l0} !== exp) begin
                errors++;
                $display("FAIL ovf_drain_beat%0d: got v/d/i/l=%h want %h", k, {v0, d0, i0, l0}, exp);
            end
            step();
        end
        checks++;
        if ({v0, o0} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_end: got out_valid=%0b overflow=%0b want 0 1", v0, o0);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [12:0] exp;
        out_ready = 1'b1;
        pulse(60, 61, 62, 63, 64);
        step();
        step();
        checks++;
        if ({v0, i0} !== 4'b1010) begin
            errors++;
            $display("FAIL mid_drain_pos: got out_valid=%0b index=%0d want 1 2", v0, i0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({v0, d0, i0, l0, s0, o0} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got v=%0b d=%0d i=%0d l=%0b s=%0b ovf=%0b want all 0", v0, d0, i0, l0, s0, o0);
        end
        pulse(70, 71, 72, 73, 74);
        for (int k = 0; k < 5; k++) begin
            exp = {1'b1, 8'(70 + k), 3'(k), (k == 4)};
            checks++;
            if ({v0, d0, i0, l0} !== exp) begin
                errors++;
                $display("FAIL post_reset_beat%0d: got v/d/i/l=%h want %h", k, {v0, d0, i0, l0}, exp);
            end
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        acc_1 = '0; acc_2 = '0; acc_3 = '0; acc_4 = '0; acc_5 = '0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        test_reset();
        test_basic();
        test_quantize();
        test_stall();
        test_back_to_back();
        test_same_edge();
        test_overflow();
        test_reset_mid_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
